// File: rtl/id_issue_skid_reg.sv
// ID->IS pipeline register with a 2-entry skid buffer, per-way delay-slot flags and the
// first-valid-branch descriptor for the branch predictor.
module id_issue_skid_reg #(
   parameter int unsigned     WAYS     = 2,
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     INFO_W   = 55,
   parameter int unsigned     VLD_W    = 6,
   parameter int unsigned     EXC_W    = 5,
   parameter int unsigned     PTAB_W   = 5,
   parameter int unsigned     BTYPE_W  = 3,
   parameter logic [EXC_W-1:0] EXC_NONE = '0,
   localparam int unsigned    BW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_allin,
   input  logic [WAYS-1:0]           in_way_valid,
   input  logic [WAYS*PC_W-1:0]      in_pc,
   input  logic [WAYS*PTAB_W-1:0]    in_ptab,
   input  logic [WAYS*INFO_W-1:0]    in_info,
   input  logic [WAYS*VLD_W-1:0]     in_dvld,
   input  logic [WAYS*EXC_W-1:0]     in_exc,
   input  logic [WAYS-1:0]           in_br_en,
   input  logic [WAYS*BTYPE_W-1:0]   in_br_type,
   input  logic [WAYS*PC_W-1:0]      in_br_tgt,
   output logic                      out_valid,
   input  logic                      out_allin,
   output logic [WAYS-1:0]           out_way_valid,
   output logic [WAYS*PC_W-1:0]      out_pc,
   output logic [WAYS*PTAB_W-1:0]    out_ptab,
   output logic [WAYS*INFO_W-1:0]    out_info,
   output logic [WAYS*VLD_W-1:0]     out_dvld,
   output logic [WAYS*EXC_W-1:0]     out_exc,
   output logic [WAYS-1:0]           out_delot,
   output logic                      out_br_en,
   output logic [BW-1:0]             out_br_way,
   output logic [PC_W-1:0]           out_br_pc,
   output logic [BTYPE_W-1:0]        out_br_type,
   output logic [PC_W-1:0]           out_br_tgt
);

   typedef struct packed {
      logic [WAYS-1:0]         way_valid;
      logic [WAYS*PC_W-1:0]    pc;
      logic [WAYS*PTAB_W-1:0]  ptab;
      logic [WAYS*INFO_W-1:0]  info;
      logic [WAYS*VLD_W-1:0]   dvld;
      logic [WAYS*EXC_W-1:0]   exc;
      logic [WAYS-1:0]         delot;
      logic                    br_en;
      logic [BW-1:0]           br_way;
      logic [PC_W-1:0]         br_pc;
      logic [BTYPE_W-1:0]      br_type;
      logic [PC_W-1:0]         br_tgt;
   } entry_t;

   entry_t main_q, main_d, skid_q, skid_d, in_entry;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   carry_q, carry_d;
   logic   accept, pop;
   logic   found;

   function automatic entry_t clear_entry();
      entry_t e;
      e     = '0;
      e.exc = {WAYS{EXC_NONE}};
      return e;
   endfunction

   assign in_allin  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign accept    = in_valid & in_allin;
   assign pop       = main_valid_q & out_allin;

   // Incoming bundle as it will be stored: raw fields plus derived delay-slot/branch info.
   always_comb begin
      in_entry           = '0;
      found              = 1'b0;
      in_entry.way_valid = in_way_valid;
      in_entry.pc        = in_pc;
      in_entry.ptab      = in_ptab;
      in_entry.info      = in_info;
      in_entry.dvld      = in_dvld;
      in_entry.exc       = in_exc;
      in_entry.delot[0]  = in_way_valid[0] & carry_q;
      for (int i = 1; i < WAYS; i++) begin
         in_entry.delot[i] = in_way_valid[i] & in_way_valid[i-1] & in_br_en[i-1];
      end
      for (int i = 0; i < WAYS; i++) begin
         if (!found && in_way_valid[i] && in_br_en[i]) begin
            found            = 1'b1;
            in_entry.br_en   = 1'b1;
            in_entry.br_way  = i[BW-1:0];
            in_entry.br_pc   = in_pc[i*PC_W +: PC_W];
            in_entry.br_type = in_br_type[i*BTYPE_W +: BTYPE_W];
            in_entry.br_tgt  = in_br_tgt[i*PC_W +: PC_W];
         end
      end
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      carry_d      = carry_q;
      if (flush) begin
         main_d       = clear_entry();
         skid_d       = clear_entry();
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         carry_d      = 1'b0;
      end else begin
         // Carry follows the highest-indexed valid way; an empty bundle keeps it.
         if (accept) begin
            for (int i = 0; i < WAYS; i++) begin
               if (in_way_valid[i]) carry_d = in_br_en[i];
            end
         end
         if (!main_valid_q) begin
            if (accept) begin
               main_d       = in_entry;
               main_valid_d = 1'b1;
            end
         end else if (!skid_valid_q) begin
            if (accept && pop) begin
               main_d = in_entry;
            end else if (accept) begin
               skid_d       = in_entry;
               skid_valid_d = 1'b1;
            end else if (pop) begin
               main_d       = clear_entry();
               main_valid_d = 1'b0;
            end
         end else if (pop) begin
            main_d       = skid_q;
            skid_d       = clear_entry();
            skid_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         main_q       <= clear_entry();
         skid_q       <= clear_entry();
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         carry_q      <= carry_d;
      end
   end

   assign out_way_valid = main_q.way_valid;
   assign out_pc        = main_q.pc;
   assign out_ptab      = main_q.ptab;
   assign out_info      = main_q.info;
   assign out_dvld      = main_q.dvld;
   assign out_exc       = main_q.exc;
   assign out_delot     = main_q.delot;
   assign out_br_en     = main_q.br_en;
   assign out_br_way    = main_q.br_way;
   assign out_br_pc     = main_q.br_pc;
   assign out_br_type   = main_q.br_type;
   assign out_br_tgt    = main_q.br_tgt;

endmodule

// File: doc/id_issue_skid_reg.md
Name: id_issue_skid_reg

Overview:
- Parametrised successor of the dual-issue ID→IS pipeline register.
- Accepts a WAYS-wide decoded bundle from the external per-way decoders and holds it in a 2-entry skid buffer (main + skid), so the upstream ready (in_allin) is registered rather than combinational from out_allin.
- Per way, computes the delay-slot flag, including across bundle boundaries.
- Produces the first-valid-branch descriptor for the branch predictor, aligned with each stored bundle.

Parameters:
- WAYS, 2, decode ways per bundle (≥1).
- PC_W, 32, PC width.
- INFO_W, 55, decode-info width per way.
- VLD_W, 6, decode-valid field width per way.
- EXC_W, 5, exception-code width per way.
- PTAB_W, 5, PTAB address width per way.
- BTYPE_W, 3, branch-type width.
- EXC_NONE, 0, "no exception" code; reset value of exception fields.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream bundle valid.
- in_allin  out  1  ready to accept a bundle; registered.
- in_way_valid  in  WAYS  per-way instruction valid.
- in_pc  in  WAYS*PC_W  per-way PC; way 0 in the LSBs.
- in_ptab  in  WAYS*PTAB_W  per-way PTAB address.
- in_info  in  WAYS*INFO_W  per-way decode info.
- in_dvld  in  WAYS*VLD_W  per-way decode-valid field.
- in_exc  in  WAYS*EXC_W  per-way exception code.
- in_br_en  in  WAYS  per-way "is branch".
- in_br_type  in  WAYS*BTYPE_W  per-way branch type.
- in_br_tgt  in  WAYS*PC_W  per-way branch target.
- out_valid  out  1  stored bundle valid.
- out_allin  in  1  downstream ready.
- out_way_valid, out_pc, out_ptab, out_info, out_dvld, out_exc  out  same widths as the inputs  stored fields.
- out_delot  out  WAYS  per-way delay-slot flag.
- out_br_en  out  1  bundle contains a valid branch.
- out_br_way  out  clog2(WAYS) (min 1)  index of the first valid branch way.
- out_br_pc  out  PC_W  PC of that branch.
- out_br_type  out  BTYPE_W  type of that branch.
- out_br_tgt  out  PC_W  target of that branch.

Behaviour:
Handshakes and state:
- accept = in_valid & in_allin.
- pop = out_valid & out_allin.
- State: main entry (drives the out_* ports) and skid entry; occupancy cnt ∈ {0,1,2}.
- in_allin = !skid_valid. out_valid = main_valid.

Occupancy transitions (per cycle, no flush):
- cnt0: accept → main ← in; cnt1.
- cnt1: accept & pop → main ← in, stays 1. accept only → skid ← in; cnt2. pop only → cnt0.
- cnt2: no accept possible (in_allin=0). pop → main ← skid, skid invalid; cnt1.
- Bundle order is preserved. Stored entries never change while held.

Delay-slot flags (computed at accept, stored with the entry):
- delot[0] = carry.
- delot[i] = in_way_valid[i-1] & in_br_en[i-1], for i ≥ 1.
- A flag is forced to 0 on a way whose in_way_valid is 0.

Carry register:
- Updated only on accept.
- carry ← 1 iff the highest-indexed valid way of the accepted bundle has in_br_en set.
- Otherwise carry ← 0, including when delot[0] consumed the previous carry.
- A bundle with no valid ways leaves carry unchanged.

Branch descriptor (computed at accept, stored with the entry):
- Lowest-index way i with in_way_valid[i] & in_br_en[i].
- br_en = 1 if such a way exists; br_way, br_pc, br_type and br_tgt are taken from that way.
- If none exists: br_en = 0, all other branch fields 0.

Flush:
- Takes priority over accept and pop in the same cycle; the incoming bundle is dropped.
- Next cycle: cnt=0, main and skid invalid, carry=0, in_allin=1.

Reset (asynchronous, rst_=1) and flush, entry fields:
- main_valid=0, skid_valid=0, carry=0.
- All out_* data fields = 0, except out_exc = {WAYS{EXC_NONE}}.
- Reset asserted mid-transfer discards all held bundles.

Invariants:
- out_* values are undefined-free (all zero) when out_valid=0.
- Combinational paths allowed only from in_* to internal next-state; no in_valid → in_allin or out_allin → in_allin path.

Test Plan:
- WAYS=2; bundle ways {valid, valid}, br_en={0,1}, then next bundle {valid, valid}, br_en={0,0} → first out_delot=00; second out_delot=01 (way0 is the delay slot); carry=0 afterwards.
- br_en={1,0}, pc={0x1000,0x1004}, tgt0=0x2000 → out_delot=10, out_br_en=1, out_br_way=0, out_br_pc=0x1000, out_br_tgt=0x2000.
- Hold out_allin=0 and offer 3 bundles A, B, C → A in main, B in skid, in_allin=0 from the cycle after B is accepted, C held upstream. Raise out_allin → pops A, B, C in order; in_allin returns to 1 the cycle after the first pop.
- flush asserted together with accept while cnt=2 → next cycle out_valid=0, in_allin=1, carry=0, out_exc=EXC_NONE per way; the dropped bundle never appears at the output.
- Assert rst_ asynchronously mid-cycle with cnt=1 → out_valid falls immediately with no clock edge; all outputs at their reset values.
- Bundle with way1 invalid and br_en[0]=1 → carry=1; next bundle's out_delot[0]=1, and out_delot[1]=0 unless way0 of that bundle is a valid branch.
